// File: rtl/swkey_pkg.sv
// ---------------------------------------------------------------------------
// swkey_pkg
// Shared types and constants for the switch/key input peripheral.
//   word_t                  32-bit bus word
//   swkey_addr_e            word register index on the CPU bus
//   SWKEY_DEBOUNCE_DEFAULT  default debounce length in clock cycles
// ---------------------------------------------------------------------------
package swkey_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    SWKEY_SW   = 2'd0,
    SWKEY_KEY  = 2'd1,
    SWKEY_EDGE = 2'd2,
    SWKEY_MASK = 2'd3
  } swkey_addr_e;

  localparam int unsigned SWKEY_DEBOUNCE_DEFAULT = 500000;

endpackage

// File: rtl/switch_key_port_if.sv
// ---------------------------------------------------------------------------
// switch_key_port_if
// CPU-side register bus of the switch/key peripheral.
//   chipSelect  peripheral select
//   read        read strobe, qualified by chipSelect
//   write       write strobe, qualified by chipSelect
//   address     word register index (swkey_addr_e)
//   writeData   write data word
//   readData    registered read data word
// Modports: master (CPU side), slave (peripheral side).
// ---------------------------------------------------------------------------
interface switch_key_port_if;
  import swkey_pkg::*;

  logic       chipSelect;
  logic       read;
  logic       write;
  logic [1:0] address;
  word_t      writeData;
  word_t      readData;

  modport master (
    output chipSelect, read, write, address, writeData,
    input  readData
  );

  modport slave (
    input  chipSelect, read, write, address, writeData,
    output readData
  );

endinterface

// File: rtl/key_debouncer.sv
// ---------------------------------------------------------------------------
// key_debouncer
// Debounces one already-synchronised, active-low push-button level.
// A change is accepted only after DEBOUNCE_CYCLES consecutive cycles in which
// the synced level differs from the stable level; any bounce back restarts.
//   clk       system clock
//   rst       asynchronous active-low reset (stable level -> released)
//   i_level   synchronised key level (0 = pressed)
//   o_stable  debounced key level (0 = pressed)
//   o_press   one-cycle pulse, high on the edge where stable goes released->pressed
// ---------------------------------------------------------------------------
module key_debouncer
  import swkey_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = SWKEY_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_stable,
  output logic o_press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  // The counter is compared one short of the target so the stable update
  // lands on the edge where the count would reach DEBOUNCE_CYCLES; it never
  // actually stores that value, so it cannot wrap.
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_stable;
  logic          w_diff;
  logic          w_accept;

  assign w_diff   = (i_level != r_stable);
  assign w_accept = w_diff && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_stable <= 1'b1;
    end else if (w_accept) begin
      r_stable <= i_level;
      r_cnt    <= '0;
    end else if (w_diff) begin
      r_cnt    <= r_cnt + 1'b1;
    end else begin
      r_cnt    <= '0;
    end
  end

  assign o_stable = r_stable;
  // Combinational so the edge register sets on the same clock edge as the
  // stable update.
  assign o_press  = w_accept && !i_level;

endmodule

// File: rtl/switch_key_port.sv
// ---------------------------------------------------------------------------
// switch_key_port
// Memory-mapped input peripheral: synchronised slide switches, debounced
// push-buttons and latched button-press edges, read over a word register bus.
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   register bus (switch_key_port_if.slave)
//   sw    raw slide switches, asynchronous, 1 = on
//   key   raw push-buttons, asynchronous, 0 = pressed
//   irq   level interrupt, only when SWKEY_IRQ_EN is defined
// Register map: 0 SW (RO), 1 KEY (RO, 1 = pressed), 2 EDGE (W1C),
//               3 MASK (RW with SWKEY_IRQ_EN, otherwise reads 0).
// Optional feature macro: SWKEY_IRQ_EN (adds irq port and MASK register).
// ---------------------------------------------------------------------------
module switch_key_port
  import swkey_pkg::*;
#(
  parameter int unsigned N_SW            = 10,
  parameter int unsigned N_KEY           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = SWKEY_DEBOUNCE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  switch_key_port_if.slave  bus,
  input  logic [N_SW-1:0]   sw,
  input  logic [N_KEY-1:0]  key
`ifdef SWKEY_IRQ_EN
  ,
  output logic              irq
`endif
);

  logic [N_SW-1:0]  r_sw_meta;
  logic [N_SW-1:0]  r_sw_sync;
  logic [N_KEY-1:0] r_key_meta;
  logic [N_KEY-1:0] r_key_sync;
  logic [N_KEY-1:0] r_edge;
  word_t            r_rdata;

  logic [N_KEY-1:0] w_stable;
  logic [N_KEY-1:0] w_press;
  logic [N_KEY-1:0] w_clr;
  logic             w_rd;
  logic             w_wr;
  word_t            w_rdata;
  logic             w_unused_wdata;

  // Only the low N_KEY bits of writeData are meaningful.
  assign w_unused_wdata = ^bus.writeData;

  // Two-flop synchronisers; keys reset to released (all ones).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
      r_key_meta <= '1;
      r_key_sync <= '1;
    end else begin
      r_sw_meta  <= sw;
      r_sw_sync  <= r_sw_meta;
      r_key_meta <= key;
      r_key_sync <= r_key_meta;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < int'(N_KEY); gi++) begin : g_key
      key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debouncer (
        .clk      (clk),
        .rst      (rst),
        .i_level  (r_key_sync[gi]),
        .o_stable (w_stable[gi]),
        .o_press  (w_press[gi])
      );
    end
  endgenerate

  assign w_rd  = bus.chipSelect && bus.read;
  assign w_wr  = bus.chipSelect && bus.write;
  assign w_clr = (w_wr && (bus.address == SWKEY_EDGE)) ? bus.writeData[N_KEY-1:0] : '0;

  // A press arriving on the same edge as a clear of that bit wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_edge <= '0;
    end else begin
      r_edge <= (r_edge & ~w_clr) | w_press;
    end
  end

`ifdef SWKEY_IRQ_EN
  logic [N_KEY-1:0] r_mask;
  logic             r_irq;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (w_wr && (bus.address == SWKEY_MASK)) begin
        r_mask <= bus.writeData[N_KEY-1:0];
      end
      r_irq <= |(r_edge & r_mask);
    end
  end

  assign irq = r_irq;
`endif

  always_comb begin
    w_rdata = '0;
    case (bus.address)
      SWKEY_SW:   w_rdata[N_SW-1:0]  = r_sw_sync;
      SWKEY_KEY:  w_rdata[N_KEY-1:0] = ~w_stable;
      SWKEY_EDGE: w_rdata[N_KEY-1:0] = r_edge;
      SWKEY_MASK: begin
`ifdef SWKEY_IRQ_EN
        w_rdata[N_KEY-1:0] = r_mask;
`endif
      end
      default:    w_rdata = '0;
    endcase
  end

  // Reads sample the registers before this edge's writes take effect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
    end else if (w_rd) begin
      r_rdata <= w_rdata;
    end
  end

  assign bus.readData = r_rdata;

endmodule
